sine_voice_sequencer: RTL and testbench

- Time-multiplexes one shared quarter-wave sine pipeline among NUM_VOICES oscillator voices.
- On each sample tick it advances every voice's 16-bit phase accumulator and issues one phase per cycle to the sine unit.
- It collects the results SINE_LAT cycles later and outputs one mixed, scaled 16-bit sample.
- Sits between the sample-rate timer/config bus and the audio output path.

---
 rtl/sine_voice_seq_pkg.sv | 16 +
 rtl/sine_voice_regfile.sv | 63 ++++++
 rtl/sine_voice_sequencer.sv | 119 +++++++++++
 tb/tb_sine_voice_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sine_voice_seq_pkg.sv
// Shared types and constants for the time-multiplexed sine voice sequencer.
package sine_voice_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    localparam int PHASE_W        = 16;
    localparam int SAMPLE_W       = 16;
    localparam int DEF_NUM_VOICES = 8;
    localparam int DEF_SINE_LAT   = 3;

endpackage

// File: rtl/sine_voice_regfile.sv
// Per-voice tuning/gate/phase storage with a config write port and an indexed read/advance port.
// Optional build macro SINE_VOICE_SEQ_PHASE_RESTART_EN: a gate 0->1 write also zeroes that voice's phase.
module sine_voice_regfile
    import sine_voice_seq_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int VIDX_W     = $clog2(NUM_VOICES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [VIDX_W-1:0]  cfg_voice,
    input  logic [PHASE_W-1:0] cfg_tuning,
    input  logic               cfg_gate,
    input  logic [VIDX_W-1:0]  rd_voice,
    input  logic               adv_en,
    output logic [PHASE_W-1:0] rd_phase,
    output logic               rd_gate
);

    logic [PHASE_W-1:0]    phase_vec [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_vec;

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            logic [PHASE_W-1:0] phase_reg;
            logic [PHASE_W-1:0] tuning_reg;
            logic               gate_reg;
            logic               sel_wr;
            logic               sel_adv;

            assign sel_wr  = cfg_we && (cfg_voice == VIDX_W'(gi));
            assign sel_adv = adv_en && (rd_voice == VIDX_W'(gi));

            // Advance sees the pre-write tuning/gate, so a same-cycle write lands on the next frame.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    phase_reg  <= '0;
                    tuning_reg <= '0;
                    gate_reg   <= 1'b0;
                end else begin
                    if (sel_adv && gate_reg)
                        phase_reg <= phase_reg + tuning_reg;
`ifdef SINE_VOICE_SEQ_PHASE_RESTART_EN
                    if (sel_wr && cfg_gate && !gate_reg)
                        phase_reg <= '0;
`endif
                    if (sel_wr) begin
                        tuning_reg <= cfg_tuning;
                        gate_reg   <= cfg_gate;
                    end
                end
            end

            assign phase_vec[gi] = phase_reg;
            assign gate_vec[gi]  = gate_reg;
        end
    endgenerate

    assign rd_phase = phase_vec[rd_voice];
    assign rd_gate  = gate_vec[rd_voice];

endmodule

// File: rtl/sine_voice_sequencer.sv
// Shares one sine pipeline among NUM_VOICES voices: issue phases, accumulate results, emit a scaled mix.
// Optional build macro SINE_VOICE_SEQ_PHASE_RESTART_EN (handled in sine_voice_regfile).
module sine_voice_sequencer
    import sine_voice_seq_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int SINE_LAT   = DEF_SINE_LAT,
    parameter int VIDX_W     = $clog2(NUM_VOICES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_sample_tick,
    input  logic                i_cfg_we,
    input  logic [VIDX_W-1:0]   i_cfg_voice,
    input  logic [PHASE_W-1:0]  i_cfg_tuning,
    input  logic                i_cfg_gate,
    output logic [PHASE_W-1:0]  o_phase,
    input  logic [SAMPLE_W-1:0] i_sine_val,
    output logic [SAMPLE_W-1:0] o_sample,
    output logic                o_valid,
    output logic                o_busy,
    output logic                o_overrun
);

    localparam int ACC_W  = SAMPLE_W + VIDX_W;
    localparam int DCNT_W = $clog2(SINE_LAT + 2);

    state_t                    state_reg;
    logic [VIDX_W-1:0]         voice_cnt_reg;
    logic [DCNT_W-1:0]         drain_cnt_reg;
    logic [SINE_LAT:0]         vld_pipe_reg;
    logic signed [ACC_W-1:0]   acc_reg;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W-1:0]   term;
    logic [SAMPLE_W-1:0]       sample_next;
    logic [PHASE_W-1:0]        rd_phase;
    logic                      rd_gate;
    logic                      issuing;

    assign issuing = (state_reg == ST_ISSUE);

    sine_voice_regfile #(
        .NUM_VOICES (NUM_VOICES),
        .VIDX_W     (VIDX_W)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (i_cfg_we),
        .cfg_voice  (i_cfg_voice),
        .cfg_tuning (i_cfg_tuning),
        .cfg_gate   (i_cfg_gate),
        .rd_voice   (voice_cnt_reg),
        .adv_en     (issuing),
        .rd_phase   (rd_phase),
        .rd_gate    (rd_gate)
    );

    // Stage 0 lines up with o_phase; the last stage lines up with i_sine_val SINE_LAT cycles on.
    always_comb begin
        term        = vld_pipe_reg[SINE_LAT] ? {{VIDX_W{i_sine_val[SAMPLE_W-1]}}, i_sine_val} : '0;
        acc_next    = acc_reg + term;
        sample_next = SAMPLE_W'(acc_next >>> VIDX_W);
    end

    // DRAIN runs SINE_LAT+1 cycles: the sine latency plus the o_phase output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            voice_cnt_reg <= '0;
            drain_cnt_reg <= '0;
            vld_pipe_reg  <= '0;
            acc_reg       <= '0;
            o_phase       <= '0;
            o_sample      <= '0;
            o_valid       <= 1'b0;
            o_busy        <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            vld_pipe_reg <= {vld_pipe_reg[SINE_LAT-1:0], issuing && rd_gate};
            if (i_sample_tick && (state_reg != ST_IDLE))
                o_overrun <= 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (i_sample_tick) begin
                        state_reg     <= ST_ISSUE;
                        acc_reg       <= '0;
                        voice_cnt_reg <= '0;
                        o_busy        <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    o_phase       <= rd_phase;
                    acc_reg       <= acc_next;
                    voice_cnt_reg <= voice_cnt_reg + VIDX_W'(1);
                    if (voice_cnt_reg == VIDX_W'(NUM_VOICES - 1)) begin
                        state_reg     <= ST_DRAIN;
                        drain_cnt_reg <= '0;
                    end
                end
                ST_DRAIN: begin
                    acc_reg       <= acc_next;
                    drain_cnt_reg <= drain_cnt_reg + DCNT_W'(1);
                    if (drain_cnt_reg == DCNT_W'(SINE_LAT)) begin
                        o_sample  <= sample_next;
                        o_valid   <= 1'b1;
                        state_reg <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    o_valid   <= 1'b0;
                    o_busy    <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sine_voice_sequencer.sv
// Directed bench for sine_voice_sequencer with a latency-accurate sine stub and scoreboard queues.
module tb_sine_voice_sequencer;

    localparam int NV  = 8;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_sample_tick = 1'b0;
    logic        i_cfg_we = 1'b0;
    logic [2:0]  i_cfg_voice = '0;
    logic [15:0] i_cfg_tuning = '0;
    logic        i_cfg_gate = 1'b0;
    logic [15:0] o_phase;
    logic [15:0] i_sine_val;
    logic [15:0] o_sample;
    logic        o_valid;
    logic        o_busy;
    logic        o_overrun;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          frame_no = 0;

    logic        stub_mode = 1'b0;
    logic [15:0] stub_const = 16'h0000;
    logic [15:0] stub_p1 = '0;
    logic [15:0] stub_p2 = '0;

    logic [15:0] m_phase [NV];
    logic [15:0] m_tune  [NV];
    logic        m_gate  [NV];
    logic [15:0] ph_q [$];
    logic [15:0] samp_q [$];

    sine_voice_sequencer #(.NUM_VOICES(NV), .SINE_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_sample_tick(i_sample_tick),
        .i_cfg_we     (i_cfg_we),
        .i_cfg_voice  (i_cfg_voice),
        .i_cfg_tuning (i_cfg_tuning),
        .i_cfg_gate   (i_cfg_gate),
        .o_phase      (o_phase),
        .i_sine_val   (i_sine_val),
        .o_sample     (o_sample),
        .o_valid      (o_valid),
        .o_busy       (o_busy),
        .o_overrun    (o_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] stub_fn(input logic [15:0] p);
        return stub_mode ? p : stub_const;
    endfunction

    // Shared sine unit model: result for the phase shown in cycle c appears in cycle c+LAT.
    always @(posedge clk) begin
        stub_p1    <= stub_fn(o_phase);
        stub_p2    <= stub_p1;
        i_sine_val <= stub_p2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h required %h", tag, obs, exp);
            $error("check %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = '0;
            m_tune[v]  = '0;
            m_gate[v]  = 1'b0;
        end
    endtask

    task automatic model_write(input int v, input logic [15:0] tune, input logic gate);
`ifdef SINE_VOICE_SEQ_PHASE_RESTART_EN
        if (gate && !m_gate[v]) m_phase[v] = '0;
`endif
        m_tune[v] = tune;
        m_gate[v] = gate;
    endtask

    task automatic cfg_write(input int v, input logic [15:0] tune, input logic gate);
        i_cfg_we     = 1'b1;
        i_cfg_voice  = 3'(v);
        i_cfg_tuning = tune;
        i_cfg_gate   = gate;
        @(posedge clk); #1;
        i_cfg_we = 1'b0;
        model_write(v, tune, gate);
    endtask

    // ovr_k: loop slot at which a second tick is driven (-1 none); wr_v: voice rewritten on its own issue cycle (-1 none).
    task automatic run_frame(input int ovr_k, input int wr_v, input logic [15:0] wr_tune);
        int          t0;
        int          budget;
        int signed   sum;
        logic [15:0] exp_ph;
        logic [15:0] last_ph;
        logic [15:0] exp_s;
        sum = 0;
        for (int k = 0; k < NV; k++) begin
            ph_q.push_back(m_phase[k]);
            if (m_gate[k]) begin
                sum        += int'($signed(stub_fn(m_phase[k])));
                m_phase[k] = m_phase[k] + m_tune[k];
            end
        end
        samp_q.push_back(16'(sum >>> 3));

        i_sample_tick = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        i_sample_tick = 1'b0;
        chk("busy_start", {31'd0, o_busy}, 32'd1);
        @(posedge clk); #1;
        last_ph = '0;
        for (int k = 0; k < NV; k++) begin
            i_sample_tick = 1'b0;
            i_cfg_we      = 1'b0;
            exp_ph  = ph_q.pop_front();
            last_ph = exp_ph;
            chk($sformatf("phase_slot%0d", k), {16'd0, o_phase}, {16'd0, exp_ph});
            chk("no_early_valid", {31'd0, o_valid}, 32'd0);
            if (k == ovr_k) i_sample_tick = 1'b1;
            if (wr_v >= 1 && k + 1 == wr_v) begin
                i_cfg_we     = 1'b1;
                i_cfg_voice  = 3'(wr_v);
                i_cfg_tuning = wr_tune;
                i_cfg_gate   = m_gate[wr_v];
            end
            @(posedge clk); #1;
        end
        i_sample_tick = 1'b0;
        i_cfg_we      = 1'b0;
        if (wr_v >= 1) model_write(wr_v, wr_tune, m_gate[wr_v]);

        budget = 10;
        while (!o_valid && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        chk("valid_seen", {31'd0, o_valid}, 32'd1);
        chk("latency", cyc - t0, 32'd13);
        exp_s = samp_q.pop_front();
        chk("sample", {16'd0, o_sample}, {16'd0, exp_s});
        chk("busy_at_valid", {31'd0, o_busy}, 32'd1);
        $display("frame %0d: sample=%h expected=%h latency=%0d overrun=%b", frame_no, o_sample, exp_s, cyc - t0, o_overrun);
        frame_no++;
        @(posedge clk); #1;
        chk("valid_one_cycle", {31'd0, o_valid}, 32'd0);
        chk("busy_end", {31'd0, o_busy}, 32'd0);
        chk("phase_hold", {16'd0, o_phase}, {16'd0, last_ph});
    endtask

    initial begin
        bit seen_valid;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_phase", {16'd0, o_phase}, 32'd0);
        chk("rst_sample", {16'd0, o_sample}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_overrun", {31'd0, o_overrun}, 32'd0);

        // All gates off: loud stub must not leak into the mix.
        stub_mode = 1'b0; stub_const = 16'h7FFF;
        run_frame(-1, -1, 16'h0);

        for (int v = 0; v < NV; v++) cfg_write(v, 16'h0400, 1'b1);
        stub_const = 16'h1000;
        run_frame(-1, -1, 16'h0);
        run_frame(-1, -1, 16'h0);
        stub_const = 16'hF000;
        run_frame(-1, -1, 16'h0);

        // Second tick at T+5 must be ignored but latched as overrun.
        chk("overrun_before", {31'd0, o_overrun}, 32'd0);
        run_frame(3, -1, 16'h0);
        chk("overrun_sticky", {31'd0, o_overrun}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("overrun_still", {31'd0, o_overrun}, 32'd1);

        // Reset in the middle of ISSUE.
        i_sample_tick = 1'b1;
        @(posedge clk); #1;
        i_sample_tick = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, o_busy}, 32'd0);
        chk("midrst_overrun", {31'd0, o_overrun}, 32'd0);
        chk("midrst_phase", {16'd0, o_phase}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (o_valid) seen_valid = 1'b1;
        end
        chk("no_valid_after_rst", {31'd0, seen_valid}, 32'd0);

        // Phase-dependent stub exposes slot alignment; voice 3 wraps through 0/C000/8000/4000.
        stub_mode = 1'b1;
        cfg_write(0, 16'h1234, 1'b1);
        cfg_write(3, 16'hC000, 1'b1);
        cfg_write(6, 16'h0F00, 1'b1);
        run_frame(-1, -1, 16'h0);
        run_frame(-1, -1, 16'h0);
        run_frame(-1, 6, 16'h0100);
        run_frame(-1, -1, 16'h0);
        run_frame(-1, -1, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
